vram_arbiter: RTL

Responder side of the pixel generator's video-memory interface. Answers the generator's pg_addr with pg_data on the 4-phase pixel_state schedule and time-shares the single-port synchronous video RAM with CPU read/write requests. Sits between the VGA timing/pixel generator, the CPU bus and the 9216x16 video RAM (text 0..8191, glyph 8192..9215).

---
 rtl/vram_arbiter_pkg.sv | 42 ++++
 rtl/vram_arbiter_if.sv | 49 ++++
 rtl/vram_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared constants and types for the video-memory path. The pixel generator
// and the arbiter both use these, so the memory map and the pixel_state
// encoding live in one place.
//   - VRAM_ADDR_WIDTH / VRAM_DATA_WIDTH : word address and data widths
//   - ADDR_TEXT / SIZE_TEXT             : text plane (0..8191)
//   - ADDR_GLYPH / SIZE_GLYPH           : glyph plane (8192..9215)
//   - MEM_WORDS                         : implemented RAM depth
//   - pixel_state_e                     : 4-phase per-pixel schedule
//   - cpu_state_e                       : CPU access FSM states
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_WIDTH = 15;
    localparam int VRAM_DATA_WIDTH = 16;

    localparam int ADDR_TEXT  = 0;
    localparam int SIZE_TEXT  = 8192;
    localparam int ADDR_GLYPH = 8192;
    localparam int SIZE_GLYPH = 1024;
    localparam int MEM_WORDS  = ADDR_GLYPH + SIZE_GLYPH;

    typedef enum logic [1:0] {
        PS_TEXT_FETCH  = 2'd0,
        PS_GLYPH_FETCH = 2'd1,
        PS_WAIT        = 2'd2,
        PS_DRAW        = 2'd3
    } pixel_state_e;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_CAP  = 2'd1,
        CPU_DONE = 2'd2
    } cpu_state_e;

    // With video off every cycle belongs to the CPU; with video on only WAIT.
    function automatic logic is_cpu_slot(input logic video_active, input pixel_state_e ps);
        return !video_active || (ps == PS_WAIT);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the three buses around the arbiter.
//   video side : video_active, pixel_state, pg_addr -> pg_data
//   cpu side   : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ack
//   ram side   : mem_addr, mem_wdata, mem_we <- mem_rdata
// modport slave  : the arbiter
// modport master : everything around it (generator, CPU, RAM / bench)
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDR_WIDTH = vram_arbiter_pkg::VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = vram_arbiter_pkg::VRAM_DATA_WIDTH
);
    import vram_arbiter_pkg::*;

    logic                  video_active;
    pixel_state_e          pixel_state;
    logic [ADDR_WIDTH-1:0] pg_addr;
    logic [DATA_WIDTH-1:0] pg_data;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  video_active, pixel_state, pg_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output pg_data, cpu_rdata, cpu_ack,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output video_active, pixel_state, pg_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  pg_data, cpu_rdata, cpu_ack,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Time-shares the single-port synchronous video RAM (read latency 1) between
// the pixel generator's 4-phase fetch schedule and CPU read/write requests.
// Ports:
//   clk   : system clock, four clocks per pixel
//   reset : synchronous, active-high
//   bus   : vram_arbiter_if.slave (video, cpu and ram signal groups)
//
// CPU FSM
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   CPU_IDLE | waiting; grant is combinational on slot & req in this state
//   CPU_CAP  | cycle after grant; capture read data, schedule ack
//   CPU_DONE | cpu_ack high; cpu_req ignored, back to IDLE next
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_WIDTH = vram_arbiter_pkg::VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = vram_arbiter_pkg::VRAM_DATA_WIDTH,
    parameter int MEM_WORDS  = vram_arbiter_pkg::MEM_WORDS
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    import vram_arbiter_pkg::*;

    // One extra bit so a depth of 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] LP_MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);

    cpu_state_e            r_state;
    logic                  r_we;
    logic                  r_in_range;
    logic                  r_cpu_ack;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_glyph_hold;
    logic [DATA_WIDTH-1:0] r_pg_last;

    logic                  w_in_range;
    logic                  w_slot;
    logic                  w_grant;
    logic                  w_video_fetch;
    logic [DATA_WIDTH-1:0] w_pg_data;

    assign w_in_range    = {1'b0, bus.cpu_addr} < LP_MEM_LIMIT;
    assign w_slot        = is_cpu_slot(bus.video_active, bus.pixel_state);
    assign w_video_fetch = bus.video_active && (bus.pixel_state != PS_WAIT);
    // Gated by reset so nothing is written in a reset cycle.
    assign w_grant       = !reset && w_slot && bus.cpu_req && (r_state == CPU_IDLE);

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (w_grant) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_we && w_in_range;
        end else if (w_video_fetch) begin
            bus.mem_addr  = bus.pg_addr;
        end
    end

    // GLYPH_FETCH shows the text word, WAIT the glyph word, both straight off
    // the RAM; DRAW and the following TEXT_FETCH replay the held glyph. With
    // video off the RAM carries CPU traffic, so the last shown value is held.
    always_comb begin
        w_pg_data = r_pg_last;
        if (bus.video_active) begin
            case (bus.pixel_state)
                PS_GLYPH_FETCH, PS_WAIT: w_pg_data = bus.mem_rdata;
                default:                 w_pg_data = r_glyph_hold;
            endcase
        end
    end

    assign bus.pg_data   = w_pg_data;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ack   = r_cpu_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CPU_IDLE;
            r_we         <= 1'b0;
            r_in_range   <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_glyph_hold <= '0;
            r_pg_last    <= '0;
        end else begin
            r_cpu_ack <= 1'b0;

            if (bus.video_active && (bus.pixel_state == PS_WAIT)) begin
                r_glyph_hold <= bus.mem_rdata;
            end
            if (bus.video_active) begin
                r_pg_last <= w_pg_data;
            end

            case (r_state)
                CPU_IDLE: begin
                    // Latch the access so it completes even if cpu_req drops.
                    if (w_grant) begin
                        r_state    <= CPU_CAP;
                        r_we       <= bus.cpu_we;
                        r_in_range <= w_in_range;
                    end
                end
                CPU_CAP: begin
                    if (!r_we) begin
                        r_cpu_rdata <= r_in_range ? bus.mem_rdata : '0;
                    end
                    r_cpu_ack <= 1'b1;
                    r_state   <= CPU_DONE;
                end
                CPU_DONE: r_state <= CPU_IDLE;
                default:  r_state <= CPU_IDLE;
            endcase
        end
    end

endmodule
